// File: rtl/id_ex_skid_pipe.sv
// ID->EX pipeline register with a 2-entry skid (output reg + skid reg), flush and stall counter.
// id_ready is a flop, so EX back-pressure never reaches ID combinationally.
module id_ex_skid_pipe #(
  parameter int DATA_W   = 32,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int RADDR_W  = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [DATA_W-1:0]   id_reg1,
  input  logic [DATA_W-1:0]   id_reg2,
  input  logic [RADDR_W-1:0]  id_wd,
  input  logic                id_wreg,
  input  logic [DATA_W-1:0]   id_link_address,
  input  logic                id_is_in_delayslot,
  input  logic                next_inst_in_delayslot_i,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [DATA_W-1:0]   ex_reg1,
  output logic [DATA_W-1:0]   ex_reg2,
  output logic [RADDR_W-1:0]  ex_wd,
  output logic                ex_wreg,
  output logic [DATA_W-1:0]   ex_link_address,
  output logic                ex_is_in_delayslot,
  output logic                is_in_delayslot_o,
  output logic [CNT_W-1:0]    stall_cycles
);

  typedef struct packed {
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [DATA_W-1:0]   reg1;
    logic [DATA_W-1:0]   reg2;
    logic [RADDR_W-1:0]  wd;
    logic                wreg;
    logic [DATA_W-1:0]   link;
    logic                dslot;
  } bundle_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_e;

  typedef enum logic [1:0] {
    OUT_HOLD = 2'd0,
    OUT_IN   = 2'd1,
    OUT_SKID = 2'd2,
    OUT_NOP  = 2'd3
  } out_sel_e;

  typedef enum logic [1:0] {
    SKID_HOLD = 2'd0,
    SKID_IN   = 2'd1,
    SKID_NOP  = 2'd2
  } skid_sel_e;

  localparam bundle_t NOP = '0;

  occ_e      state_q, state_d;
  out_sel_e  out_sel;
  skid_sel_e skid_sel;

  bundle_t    in_bundle;
  bundle_t    out_q, out_d;
  bundle_t    skid_q, skid_d;
  logic       id_ready_q, id_ready_d;
  logic       dslot_q, dslot_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic acc;
  logic pop;
  logic valid_out;

  assign in_bundle = '{
    aluop:  id_aluop,
    alusel: id_alusel,
    reg1:   id_reg1,
    reg2:   id_reg2,
    wd:     id_wd,
    wreg:   id_wreg,
    link:   id_link_address,
    dslot:  id_is_in_delayslot
  };

  assign valid_out = (state_q != S_EMPTY);
  assign acc       = id_valid & id_ready_q;
  assign pop       = valid_out & ex_ready;

  // Occupancy FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (acc) state_d = S_ONE;
        S_ONE: begin
          if (acc && !pop)      state_d = S_FULL;
          else if (!acc && pop) state_d = S_EMPTY;
        end
        S_FULL:  if (pop) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Occupancy FSM: datapath steering
  always_comb begin
    out_sel  = OUT_HOLD;
    skid_sel = SKID_HOLD;
    if (flush) begin
      out_sel  = OUT_NOP;
      skid_sel = SKID_NOP;
    end else begin
      case (state_q)
        S_EMPTY: if (acc) out_sel = OUT_IN;
        S_ONE: begin
          if (acc && pop)  out_sel  = OUT_IN;
          else if (acc)    skid_sel = SKID_IN;
          else if (pop)    out_sel  = OUT_NOP;
        end
        S_FULL: begin
          if (pop) begin
            out_sel  = OUT_SKID;
            skid_sel = SKID_NOP;
          end
        end
        default: begin
          out_sel  = OUT_NOP;
          skid_sel = SKID_NOP;
        end
      endcase
    end
  end

  always_comb begin
    out_d = out_q;
    case (out_sel)
      OUT_IN:   out_d = in_bundle;
      OUT_SKID: out_d = skid_q;
      OUT_NOP:  out_d = NOP;
      default:  out_d = out_q;
    endcase
  end

  always_comb begin
    skid_d = skid_q;
    case (skid_sel)
      SKID_IN:  skid_d = in_bundle;
      SKID_NOP: skid_d = NOP;
      default:  skid_d = skid_q;
    endcase
  end

  // Ready is recomputed from next occupancy so it is valid the cycle state lands.
  assign id_ready_d = (state_d != S_FULL);

  always_comb begin
    dslot_d = dslot_q;
    if (flush)    dslot_d = 1'b0;
    else if (acc) dslot_d = next_inst_in_delayslot_i;
  end

  always_comb begin
    stall_d = stall_q;
    if (valid_out && !ex_ready && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= NOP;
      skid_q     <= NOP;
      id_ready_q <= 1'b1;
      dslot_q    <= 1'b0;
      stall_q    <= '0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      id_ready_q <= id_ready_d;
      dslot_q    <= dslot_d;
      stall_q    <= stall_d;
    end
  end

  assign id_ready           = id_ready_q;
  assign ex_valid           = valid_out;
  assign ex_aluop           = out_q.aluop;
  assign ex_alusel          = out_q.alusel;
  assign ex_reg1            = out_q.reg1;
  assign ex_reg2            = out_q.reg2;
  assign ex_wd              = out_q.wd;
  assign ex_wreg            = out_q.wreg;
  assign ex_link_address    = out_q.link;
  assign ex_is_in_delayslot = out_q.dslot;
  assign is_in_delayslot_o  = dslot_q;
  assign stall_cycles       = stall_q;

  a_nop_when_idle: assert property (@(posedge clk) disable iff (rst)
    !valid_out |-> (out_q == NOP));
  a_ready_vs_full: assert property (@(posedge clk) disable iff (rst)
    id_ready_q == (state_q != S_FULL));
  a_skid_empty: assert property (@(posedge clk) disable iff (rst)
    (state_q != S_FULL) |-> (skid_q == NOP));

endmodule
